// File: rtl/vroom_bus_pkg.sv
// Shared types for the CPU bus-master request arbiter: request bundle, widths and FSM states.
package vroom_bus_pkg;

  localparam int unsigned StrbW = 4;
  localparam int unsigned AddrW = 30;
  localparam int unsigned DataW = 512;

  typedef struct packed {
    logic [StrbW-1:0] strobe;
    logic             lineEn;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
  } bus_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitResp
  } arb_state_e;

endpackage

// File: rtl/bus_req_arbiter_if.sv
// Requester-side and bus-master-side signals of the arbiter; slave is the arbiter's view.
interface bus_req_arbiter_if #(
  parameter int unsigned N_REQ = 2
);
  import vroom_bus_pkg::*;

  logic [N_REQ-1:0]       up_reqValid;
  logic [N_REQ-1:0]       up_reqReady;
  logic [StrbW*N_REQ-1:0] up_reqByteStrobe;
  logic [N_REQ-1:0]       up_reqLineEn;
  logic [AddrW*N_REQ-1:0] up_reqAddr;
  logic [DataW*N_REQ-1:0] up_reqData;
  logic [N_REQ-1:0]       up_lock;
  logic [N_REQ-1:0]       up_respReady;
  logic [N_REQ-1:0]       up_respValid;
  logic [DataW-1:0]       up_respData;
  logic                   up_respHasError;

  logic                   ds_reqValid;
  logic                   ds_reqReady;
  logic [StrbW-1:0]       ds_reqByteStrobe;
  logic                   ds_reqLineEn;
  logic [AddrW-1:0]       ds_reqAddr;
  logic [DataW-1:0]       ds_reqData;
  logic                   ds_respValid;
  logic                   ds_respReady;
  logic [DataW-1:0]       ds_respData;
  logic                   ds_respHasError;

  modport slave (
    input  up_reqValid, up_reqByteStrobe, up_reqLineEn, up_reqAddr, up_reqData, up_lock,
    input  up_respReady,
    output up_reqReady, up_respValid, up_respData, up_respHasError,
    input  ds_reqReady, ds_respValid, ds_respData, ds_respHasError,
    output ds_reqValid, ds_reqByteStrobe, ds_reqLineEn, ds_reqAddr, ds_reqData, ds_respReady
  );

  modport master (
    output up_reqValid, up_reqByteStrobe, up_reqLineEn, up_reqAddr, up_reqData, up_lock,
    output up_respReady,
    input  up_reqReady, up_respValid, up_respData, up_respHasError,
    output ds_reqReady, ds_respValid, ds_respData, ds_respHasError,
    input  ds_reqValid, ds_reqByteStrobe, ds_reqLineEn, ds_reqAddr, ds_reqData, ds_respReady
  );

endinterface

// File: rtl/bus_rr_picker.sv
// Combinational round-robin pick: first candidate at or after rr_ptr, searching upward with wrap.
module bus_rr_picker #(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0]         cand,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     grant_valid
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base,
                                               input int unsigned    off);
    return IdxW'((32'(base) + off) % N_REQ);
  endfunction

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      if (!grant_valid && cand[wrap_idx(rr_ptr, off)]) begin
        grant_valid                   = 1'b1;
        grant_idx                     = wrap_idx(rr_ptr, off);
        grant[wrap_idx(rr_ptr, off)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_req_arbiter.sv
// Shares the CPU bus-master port among N_REQ requesters: round-robin accept with an optional
// bounded lock, one registered request in flight, read responses routed to the issuing requester.
module bus_req_arbiter
  import vroom_bus_pkg::*;
#(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bus_req_arbiter_if.slave bus
);

  localparam int unsigned IdxW     = $clog2(N_REQ);
  localparam int unsigned LockCntW = $clog2(LOCK_MAX + 1);

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic                lock_active_q, lock_active_d;
  logic [LockCntW-1:0] lock_cnt_q, lock_cnt_d;
  bus_req_t            hold_q, hold_d;
  logic                is_wr_q, is_wr_d;

  logic                lock_eff;
  logic                lock_at_max;
  logic [N_REQ-1:0]    cand;
  logic [N_REQ-1:0]    grant;
  logic [IdxW-1:0]     grant_idx;
  logic                grant_valid;
  bus_req_t            req_vec [N_REQ];

  // A lock that has reached LOCK_MAX no longer restricts arbitration.
  assign lock_at_max = (lock_cnt_q == LockCntW'(LOCK_MAX));
  assign lock_eff    = lock_active_q && !lock_at_max;

  always_comb begin
    cand = bus.up_reqValid;
    if (lock_eff) begin
      cand = bus.up_reqValid & (N_REQ'(1) << owner_q);
    end
  end

  bus_rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .cand        (cand),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_vec[i].strobe = bus.up_reqByteStrobe[i*StrbW +: StrbW];
      req_vec[i].lineEn = bus.up_reqLineEn[i];
      req_vec[i].addr   = bus.up_reqAddr[i*AddrW +: AddrW];
      req_vec[i].data   = bus.up_reqData[i*DataW +: DataW];
    end
  end

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    owner_d          = owner_q;
    lock_active_d    = lock_active_q;
    lock_cnt_d       = lock_cnt_q;
    hold_d           = hold_q;
    is_wr_d          = is_wr_q;
    bus.up_reqReady  = '0;
    bus.up_respValid = '0;
    bus.ds_reqValid  = 1'b0;
    bus.ds_respReady = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gated by rst_n so a held reset never produces an accept pulse.
        if (grant_valid && rst_n) begin
          bus.up_reqReady = grant;
          hold_d          = req_vec[grant_idx];
          owner_d         = grant_idx;
          is_wr_d         = |req_vec[grant_idx].strobe;
          rr_ptr_d        = (grant_idx == IdxW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          if (bus.up_lock[grant_idx] && !lock_at_max) begin
            lock_active_d = 1'b1;
            lock_cnt_d    = lock_cnt_q + 1'b1;
          end else begin
            lock_active_d = 1'b0;
            lock_cnt_d    = '0;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        bus.ds_reqValid = 1'b1;
        if (bus.ds_reqReady) begin
          // Writes carry no response; the bus master stalls new accepts itself.
          state_d = is_wr_q ? StIdle : StWaitResp;
        end
      end
      StWaitResp: begin
        bus.ds_respReady          = bus.up_respReady[owner_q];
        bus.up_respValid[owner_q] = bus.ds_respValid;
        if (bus.ds_respValid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.ds_reqByteStrobe = hold_q.strobe;
  assign bus.ds_reqLineEn     = hold_q.lineEn;
  assign bus.ds_reqAddr       = hold_q.addr;
  assign bus.ds_reqData       = hold_q.data;

  // Zero-latency response path, forced to zero outside WAIT_RESP.
  assign bus.up_respData     = (state_q == StWaitResp) ? bus.ds_respData : '0;
  assign bus.up_respHasError = (state_q == StWaitResp) ? bus.ds_respHasError : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      lock_active_q <= 1'b0;
      lock_cnt_q    <= '0;
      hold_q        <= '0;
      is_wr_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      lock_active_q <= lock_active_d;
      lock_cnt_q    <= lock_cnt_d;
      hold_q        <= hold_d;
      is_wr_q       <= is_wr_d;
    end
  end

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Directed bench for bus_req_arbiter (N_REQ=2, LOCK_MAX=8); the bench plays requesters and bus master.
module tb_bus_req_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [1:0] g;
  logic [1:0] gl [9];

  always #5 clk = ~clk;

  bus_req_arbiter_if #(.N_REQ(2)) bus ();

  bus_req_arbiter #(
    .N_REQ    (2),
    .LOCK_MAX (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] s, input logic le,
                         input logic [29:0] a, input logic [31:0] d);
    bus.up_reqByteStrobe[i*4 +: 4]  = s;
    bus.up_reqLineEn[i]             = le;
    bus.up_reqAddr[i*30 +: 30]      = a;
    bus.up_reqData[i*512 +: 512]    = {480'd0, d};
  endtask

  // Sample the accept pulse, then play a bus master that takes the write immediately.
  task automatic grab_write(output logic [1:0] gnt);
    #1;
    gnt = bus.up_reqReady;
    cyc();
    bus.ds_reqReady = 1'b1;
    cyc();
    bus.ds_reqReady = 1'b0;
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.up_reqValid      = '0;
    bus.up_reqByteStrobe = '0;
    bus.up_reqLineEn     = '0;
    bus.up_reqAddr       = '0;
    bus.up_reqData       = '0;
    bus.up_lock          = '0;
    bus.up_respReady     = 2'b11;
    bus.ds_reqReady      = 1'b0;
    bus.ds_respValid     = 1'b0;
    bus.ds_respData      = '0;
    bus.ds_respHasError  = 1'b0;
    cyc();

    // Reset: outputs zero even with activity on the inputs.
    bus.up_reqValid     = 2'b11;
    bus.ds_respValid    = 1'b1;
    bus.ds_respData     = {480'd0, 32'hAAAA5555};
    bus.ds_respHasError = 1'b1;
    cyc();
    #1;
    chk("rst_up_reqReady", 64'(bus.up_reqReady), 64'h0);
    chk("rst_ds_reqValid", 64'(bus.ds_reqValid), 64'h0);
    chk("rst_ds_respReady", 64'(bus.ds_respReady), 64'h0);
    chk("rst_up_respValid", 64'(bus.up_respValid), 64'h0);
    chk("rst_up_respData", 64'(bus.up_respData[31:0]), 64'h0);
    chk("rst_up_respHasError", 64'(bus.up_respHasError), 64'h0);
    chk("rst_ds_reqAddr", 64'(bus.ds_reqAddr), 64'h0);
    bus.ds_respValid    = 1'b0;
    bus.ds_respData     = '0;
    bus.ds_respHasError = 1'b0;

    // Simultaneous requests: grant order 0, 1, 0.
    set_req(0, 4'hF, 1'b0, 30'h10, 32'h1111_1111);
    set_req(1, 4'h3, 1'b0, 30'h20, 32'h2222_2222);
    rst_n = 1'b1;
    #1;
    chk("sim_grant0", 64'(bus.up_reqReady), 64'h1);
    cyc();
    #1;
    chk("sim_issue_valid", 64'(bus.ds_reqValid), 64'h1);
    chk("sim_issue_addr0", 64'(bus.ds_reqAddr), 64'h10);
    chk("sim_issue_strb0", 64'(bus.ds_reqByteStrobe), 64'hF);
    chk("sim_issue_no_grant", 64'(bus.up_reqReady), 64'h0);
    bus.ds_reqReady = 1'b1;
    cyc();
    bus.ds_reqReady = 1'b0;
    #1;
    chk("sim_idle_valid_low", 64'(bus.ds_reqValid), 64'h0);
    chk("sim_grant1", 64'(bus.up_reqReady), 64'h2);
    cyc();
    #1;
    chk("sim_issue_addr1", 64'(bus.ds_reqAddr), 64'h20);
    chk("sim_issue_data1", 64'(bus.ds_reqData[31:0]), 64'h2222_2222);
    bus.ds_reqReady = 1'b1;
    cyc();
    bus.ds_reqReady = 1'b0;
    #1;
    chk("sim_grant0_again", 64'(bus.up_reqReady), 64'h1);
    bus.up_reqValid = 2'b00;
    #1;
    chk("no_valid_no_grant", 64'(bus.up_reqReady), 64'h0);

    // Read routing: requester 1 line read, response goes only to requester 1.
    set_req(1, 4'h0, 1'b1, 30'h400, 32'h0);
    bus.up_reqValid = 2'b10;
    #1;
    chk("rd_grant", 64'(bus.up_reqReady), 64'h2);
    cyc();
    bus.up_reqValid = 2'b00;
    #1;
    chk("rd_lineEn", 64'(bus.ds_reqLineEn), 64'h1);
    chk("rd_addr", 64'(bus.ds_reqAddr), 64'h400);
    chk("rd_strb", 64'(bus.ds_reqByteStrobe), 64'h0);
    bus.ds_reqReady = 1'b1;
    cyc();
    bus.ds_reqReady = 1'b0;
    #1;
    chk("rd_respReady", 64'(bus.ds_respReady), 64'h1);
    bus.ds_respValid = 1'b1;
    bus.ds_respData  = {480'd0, 32'hDEAD_BEEF};
    #1;
    chk("rd_respValid", 64'(bus.up_respValid), 64'h2);
    chk("rd_respData", 64'(bus.up_respData[31:0]), 64'hDEAD_BEEF);
    cyc();
    bus.ds_respValid = 1'b0;
    #1;
    chk("rd_done_respValid", 64'(bus.up_respValid), 64'h0);
    chk("rd_done_respData", 64'(bus.up_respData[31:0]), 64'h0);

    // Write with 5 stall cycles: request held 6 cycles, hold register stable, no response.
    set_req(0, 4'hF, 1'b0, 30'h55, 32'h1234_5678);
    bus.up_reqValid = 2'b01;
    #1;
    chk("wr_grant", 64'(bus.up_reqReady), 64'h1);
    cyc();
    bus.up_reqValid = 2'b00;
    set_req(0, 4'h0, 1'b1, 30'h3FF, 32'h0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("wr_stall_valid", 64'(bus.ds_reqValid), 64'h1);
      chk("wr_stall_addr", 64'(bus.ds_reqAddr), 64'h55);
      chk("wr_stall_data", 64'(bus.ds_reqData[31:0]), 64'h1234_5678);
      cyc();
    end
    bus.ds_reqReady = 1'b1;
    #1;
    chk("wr_sixth_valid", 64'(bus.ds_reqValid), 64'h1);
    cyc();
    bus.ds_reqReady = 1'b0;
    #1;
    chk("wr_done_valid", 64'(bus.ds_reqValid), 64'h0);
    chk("wr_no_respValid", 64'(bus.up_respValid), 64'h0);
    chk("wr_no_respReady", 64'(bus.ds_respReady), 64'h0);

    // Lock honoured (rr_ptr is 1 here; a requester-1 write brings it back to 0).
    set_req(1, 4'h1, 1'b0, 30'h21, 32'h0);
    bus.up_reqValid = 2'b10;
    grab_write(g);
    chk("lock_pre_grant", 64'(g), 64'h2);
    set_req(0, 4'hF, 1'b0, 30'h30, 32'h3030_3030);
    bus.up_reqValid = 2'b11;
    bus.up_lock     = 2'b01;
    grab_write(g);
    chk("lock_g1", 64'(g), 64'h1);
    bus.up_reqValid = 2'b10;
    #1;
    chk("lock_hold_idle", 64'(bus.up_reqReady), 64'h0);
    cyc();
    bus.up_reqValid = 2'b11;
    grab_write(g);
    chk("lock_g2", 64'(g), 64'h1);
    bus.up_lock = 2'b00;
    grab_write(g);
    chk("lock_g3", 64'(g), 64'h1);
    grab_write(g);
    chk("lock_g4", 64'(g), 64'h2);

    // Lock limit: requester 0 keeps lock=1; 8 grants, then requester 1.
    bus.up_lock = 2'b01;
    for (int i = 0; i < 9; i++) begin
      grab_write(gl[i]);
    end
    for (int i = 0; i < 8; i++) begin
      chk("lockmax_req0", 64'(gl[i]), 64'h1);
    end
    chk("lockmax_req1", 64'(gl[8]), 64'h2);
    bus.up_lock     = 2'b00;
    bus.up_reqValid = 2'b00;

    // Response backpressure: requester 1 not ready for 4 cycles.
    set_req(1, 4'h0, 1'b1, 30'h444, 32'h0);
    bus.up_reqValid  = 2'b10;
    bus.up_respReady = 2'b01;
    #1;
    chk("bp_grant", 64'(bus.up_reqReady), 64'h2);
    cyc();
    bus.up_reqValid = 2'b00;
    bus.ds_reqReady = 1'b1;
    cyc();
    bus.ds_reqReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_respReady_low", 64'(bus.ds_respReady), 64'h0);
      chk("bp_respValid_low", 64'(bus.up_respValid), 64'h0);
      cyc();
    end
    bus.up_respReady = 2'b11;
    #1;
    chk("bp_still_waiting", 64'(bus.ds_respReady), 64'h1);
    bus.ds_respValid    = 1'b1;
    bus.ds_respData     = {480'd0, 32'hCAFE_F00D};
    bus.ds_respHasError = 1'b1;
    #1;
    chk("bp_respValid", 64'(bus.up_respValid), 64'h2);
    chk("bp_respData", 64'(bus.up_respData[31:0]), 64'hCAFE_F00D);
    chk("bp_respHasError", 64'(bus.up_respHasError), 64'h1);
    cyc();
    bus.ds_respValid    = 1'b0;
    bus.ds_respHasError = 1'b0;

    // Reset mid-ISSUE drops the captured request.
    set_req(0, 4'h0, 1'b0, 30'h77, 32'h7777_7777);
    bus.up_reqValid = 2'b01;
    #1;
    chk("mid_grant", 64'(bus.up_reqReady), 64'h1);
    cyc();
    bus.up_reqValid = 2'b00;
    #1;
    chk("mid_issue_valid", 64'(bus.ds_reqValid), 64'h1);
    chk("mid_issue_addr", 64'(bus.ds_reqAddr), 64'h77);
    rst_n = 1'b0;
    cyc();
    #1;
    chk("mid_rst_valid", 64'(bus.ds_reqValid), 64'h0);
    chk("mid_rst_addr", 64'(bus.ds_reqAddr), 64'h0);
    chk("mid_rst_data", 64'(bus.ds_reqData[31:0]), 64'h0);
    chk("mid_rst_respReady", 64'(bus.ds_respReady), 64'h0);
    rst_n           = 1'b1;
    bus.up_reqValid = 2'b11;
    #1;
    chk("mid_rst_rr_ptr", 64'(bus.up_reqReady), 64'h1);
    bus.up_reqValid = 2'b00;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_req_arbiter.md
# bus_req_arbiter

Shares the single CPU bus-master request/response port among `N_REQ` requesters, for example the core and a debug/DMA engine. It accepts one request at a time with round-robin fairness and an optional lock for atomic sequences. The accepted request is registered and replayed to the bus master. Each read response is routed back to the requester that issued it. The block sits between the requesters and the bus master, and uses the same enable-pulse handshake style as the Bluespec core.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, legal range 2..4.
- `LOCK_MAX`, default 8: maximum number of consecutive locked grants to one requester. After this count the lock is ignored.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `up_reqValid`, in, N_REQ: per-requester request pending.
- `up_reqReady`, out, N_REQ: one-cycle accept pulse, used as the requester's method enable.
- `up_reqByteStrobe`, in, 4*N_REQ: byte strobes; nonzero means write.
- `up_reqLineEn`, in, N_REQ: 16-beat line transfer when set, single beat when clear.
- `up_reqAddr`, in, 30*N_REQ: word address.
- `up_reqData`, in, 512*N_REQ: write data.
- `up_lock`, in, N_REQ: sampled at accept; requests that the next grant stay with this requester.
- `up_respReady`, in, N_REQ: requester can take a response this cycle.
- `up_respValid`, out, N_REQ: response pulse to the owning requester.
- `up_respData`, out, 512: response data, broadcast to all requesters.
- `up_respHasError`, out, 1: response error flag, broadcast to all requesters.
- `ds_reqValid`, out, 1: request presented to the bus master.
- `ds_reqReady`, in, 1: bus-master accept pulse; may be combinational from `ds_reqValid`.
- `ds_reqByteStrobe`, out, 4: registered copy of the accepted request's strobes.
- `ds_reqLineEn`, out, 1: registered copy of the accepted request's line enable.
- `ds_reqAddr`, out, 30: registered copy of the accepted request's address.
- `ds_reqData`, out, 512: registered copy of the accepted request's data.
- `ds_respValid`, in, 1: bus-master response pulse.
- `ds_respReady`, out, 1: arbiter can take a response this cycle.
- `ds_respData`, in, 512: bus-master response data.
- `ds_respHasError`, in, 1: bus-master response error flag.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT_RESP.
- **IDLE accept:**
  - Candidate set is `up_reqValid`, masked to the lock owner when `lock_active`.
  - The winner is the first candidate at or after `rr_ptr`, searching upward with wrap.
  - Assert `up_reqReady[winner]` for exactly that cycle.
  - Capture strobe, line enable, address, data and lock into the hold register.
  - Set `owner` to the winner, `is_wr` to `|strobe`, and `rr_ptr` to `(winner+1) mod N_REQ`.
  - Go to ISSUE.
- **ISSUE:**
  - `ds_reqValid` = 1, with the `ds_req*` outputs driven from the hold register.
  - On `ds_reqReady`, a write returns to IDLE; the bus master stalls further accepts until its write completes.
  - On `ds_reqReady`, a read goes to WAIT_RESP.
- **WAIT_RESP:**
  - `ds_respReady` = `up_respReady[owner]`.
  - `up_respValid[owner]` = `ds_respValid`; every other bit is 0.
  - On `ds_respValid`, go to IDLE.
- **Lock:**
  - Accepting a request with lock=1 sets `lock_active` and increments `lock_cnt`.
  - Accepting a request with lock=0 clears `lock_active` and sets `lock_cnt` to 0.
  - When `lock_cnt` equals `LOCK_MAX`, that accept is treated as unlocked: `lock_active` is cleared and `lock_cnt` is set to 0.
  - While `lock_active` and the owner is not requesting, the arbiter holds in IDLE and grants nothing, even if other requesters are valid.
- **Bus error channel:** not handled here. It stays directly between the bus master and the core.
- **Guard:** no `up_reqReady` bit is ever asserted without the matching `up_reqValid`, and at most one bit is set per cycle.

## Timing
- **Reset values:**
  - `up_reqReady`, `up_respValid`, `ds_reqValid` and `ds_respReady` are 0.
  - `ds_req*` and `up_resp*` data outputs are 0.
  - `rr_ptr`, `owner`, `lock_active` and `lock_cnt` are 0; state is IDLE.
- **Accept to bus:** accept pulse in cycle T; `ds_reqValid` asserted in T+1.
- **Write throughput:** next accept possible at T+2 at the earliest.
- **Response path:** combinational pass-through with zero added latency. Response data is not registered.
- **Combinational inputs:** `up_reqReady` depends only on `up_reqValid`, state, lock state and `rr_ptr`. It never depends on `ds_*`.
- **Reset mid-operation:** returns to IDLE in the next cycle and any captured request is dropped. The bus master shares `rst_n` and resets with the arbiter.
- **Lock counter:** `lock_cnt` saturates at `LOCK_MAX`; its width is `$clog2(LOCK_MAX+1)`.
- **Round-robin pointer:** `rr_ptr` is `$clog2(N_REQ)` bits and wraps from N_REQ-1 to 0.

## Structure
- **Package `vroom_bus_pkg`:**
  - `bus_req_t` struct: strobe[3:0], lineEn, addr[29:0], data[511:0].
  - Width constants.
  - `arb_state_e` enum: IDLE, ISSUE, WAIT_RESP.
- **Sub-module `bus_rr_picker`:** combinational. Takes the candidate mask and `rr_ptr`; returns a one-hot grant and an encoded index. The FSM and lock logic stay in `bus_req_arbiter`.

## Test plan
- **Simultaneous requests:** both requesters raise valid in the same cycle after reset → requester 0 is granted first, then requester 1 in a later accept cycle; `rr_ptr` goes 0 → 1 → 0.
- **Read routing:** requester 1 reads addr 0x0400, lineEn=1; bus master returns data with lowest word 0xDEADBEEF → only `up_respValid[1]` pulses, and `up_respData[31:0]` = 0xDEADBEEF.
- **Write then read:** requester 0 writes with strobe 0xF; the bus master delays `ds_reqReady` 5 cycles → `ds_reqValid` holds for 6 cycles and the hold register is stable. The arbiter returns to IDLE after the accept and issues no `up_respValid`.
- **Lock honoured:** requester 0 locked for 3 accepts while requester 1 is continuously valid → requester 0 gets 3 grants in a row, then requester 1 is granted.
- **Lock limit:** requester 0 holds lock=1 continuously with `LOCK_MAX`=8 → after 8 grants requester 1 is granted.
- **Response backpressure and reset:** `ds_respValid` blocked by `up_respReady`=0 for 4 cycles → `ds_respReady`=0 and state stays WAIT_RESP. Asserting `rst_n`=0 mid-ISSUE returns all outputs to 0 on the next cycle.
